// File: rtl/video_pkg.sv
// Shared video definitions: PPU host register indices and the OAM DMA state encoding.
package video_pkg;

    localparam logic [2:0] PPU_CTRL = 3'd0;
    localparam logic [2:0] PPU_MASK = 3'd1;
    localparam logic [2:0] PPU_STAT = 3'd2;
    localparam logic [2:0] OAM_ADDR = 3'd3;
    localparam logic [2:0] OAM_DATA = 3'd4;
    localparam logic [2:0] PPU_SCRL = 3'd5;
    localparam logic [2:0] PPU_ADDR = 3'd6;
    localparam logic [2:0] PPU_DATA = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StRead,
        StLatch,
        StWrite,
        StGap
    } oam_dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: copies P_count bytes from CPU page {page, 8'h00} into the PPU OAM_DATA port.
// Optional OAM_DMA_ALIGN_EN inserts one alignment clock when the start lands on an odd CPU cycle.
module oam_dma
    import video_pkg::*;
#(
    parameter int unsigned P_count   = 256,
    parameter logic [2:0]  P_oam_reg = OAM_DATA
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_start,
    input  logic [7:0]  I_page,
    input  logic        I_cpu_phase,
    output logic        O_cpu_halt,
    output logic        O_busy,
    output logic        O_done,
    output logic [15:0] O_mem_addr,
    output logic        O_mem_rden,
    input  logic [7:0]  I_mem_data,
    output logic [2:0]  O_host_addr,
    output logic        O_host_wren,
    output logic [7:0]  O_host_data
);

    localparam logic [7:0] LastIdx = 8'(P_count - 1);

    oam_dma_state_e state_q;
    logic [7:0]     page_q;
    logic [7:0]     index_q;
    logic           busy_q;
    logic           done_q;
    logic           rden_q;
    logic           wren_q;
    logic [2:0]     host_addr_q;
    logic [7:0]     host_data_q;
    logic           align_req;

`ifdef OAM_DMA_ALIGN_EN
    assign align_req = I_cpu_phase;
`else
    logic unused_cpu_phase;
    assign unused_cpu_phase = I_cpu_phase;
    assign align_req        = 1'b0;
`endif

    // Strobes are registered alongside the state so every output is glitch-free.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            state_q     <= StIdle;
            page_q      <= 8'h00;
            index_q     <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            host_addr_q <= 3'd0;
            host_data_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            rden_q <= 1'b0;
            wren_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (I_start) begin
                        page_q  <= I_page;
                        index_q <= 8'h00;
                        busy_q  <= 1'b1;
                        if (align_req) begin
                            state_q <= StAlign;
                        end else begin
                            state_q <= StRead;
                            rden_q  <= 1'b1;
                        end
                    end
                end
                StAlign: begin
                    state_q <= StRead;
                    rden_q  <= 1'b1;
                end
                StRead: begin
                    state_q <= StLatch;
                end
                StLatch: begin
                    // Read data arrives the clock after the strobe, i.e. during LATCH.
                    host_data_q <= I_mem_data;
                    host_addr_q <= P_oam_reg;
                    wren_q      <= 1'b1;
                    state_q     <= StWrite;
                end
                StWrite: begin
                    state_q <= StGap;
                end
                StGap: begin
                    if (index_q == LastIdx) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        index_q <= index_q + 8'd1;
                        state_q <= StRead;
                        rden_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign O_busy      = busy_q;
    assign O_cpu_halt  = busy_q;
    assign O_done      = done_q;
    assign O_mem_rden  = rden_q;
    assign O_mem_addr  = {page_q, index_q};
    assign O_host_wren = wren_q;
    assign O_host_addr = host_addr_q;
    assign O_host_data = host_data_q;

endmodule
